pipe_hazard_ctl: RTL and testbench



---
 rtl/pipe_hazard_ctl_if.sv | 43 ++++
 rtl/pipe_hazard_ctl.sv | 128 ++++++++++++
 tb/tb_pipe_hazard_ctl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctl_if.sv
// pipe_hazard_ctl_if
//   Bundles the decode-side request, branch resolution and the hazard
//   controller's responses into one connection.
//   master : core side; drives advance, the ID operand/destination fields and
//            br_taken; receives stall/bubble/flush, forward selects,
//            busy_regs and the event counters.
//   slave  : hazard controller; the mirror image of master.
interface pipe_hazard_ctl_if #(
  parameter int REG_BITS = 3,
  parameter int FSEL_W   = 2
);
  logic                     advance;
  logic                     id_valid;
  logic [REG_BITS-1:0]      id_ra;
  logic [REG_BITS-1:0]      id_rb;
  logic                     id_ra_used;
  logic                     id_rb_used;
  logic                     id_wr;
  logic [REG_BITS-1:0]      id_rd;
  logic                     id_late;
  logic                     br_taken;

  logic                     stall;
  logic                     bubble;
  logic                     flush;
  logic [FSEL_W-1:0]        fwd_a;
  logic [FSEL_W-1:0]        fwd_b;
  logic [2**REG_BITS-1:0]   busy_regs;
  logic [15:0]              stall_cnt;
  logic [15:0]              flush_cnt;

  modport master (
    output advance, id_valid, id_ra, id_rb, id_ra_used, id_rb_used,
           id_wr, id_rd, id_late, br_taken,
    input  stall, bubble, flush, fwd_a, fwd_b, busy_regs, stall_cnt, flush_cnt
  );

  modport slave (
    input  advance, id_valid, id_ra, id_rb, id_ra_used, id_rb_used,
           id_wr, id_rd, id_late, br_taken,
    output stall, bubble, flush, fwd_a, fwd_b, busy_regs, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctl.sv
// pipe_hazard_ctl
//   Hazard, forwarding and flush controller for the pipelined SIMPLE core.
//   Keeps a shift-register scoreboard of in-flight register writes (slot 0 =
//   ID/EX ... slot DEPTH-1 = MEM/WB), picks per-operand forward sources,
//   raises load/input-use stalls with a bubble, flushes on a taken branch and
//   counts stall/flush events (saturating).
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset; clears scoreboard and counters
//   bus   : pipe_hazard_ctl_if.slave (ID request in, hazard decisions out)
module pipe_hazard_ctl #(
  parameter int REG_BITS = 3,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int BR_STAGE = 2,
  parameter int FSEL_W   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_hazard_ctl_if.slave bus
);

  localparam int NREGS = 2**REG_BITS;

  // Scoreboard: one entry per pipeline slot behind decode.
  logic [DEPTH-1:0]    r_v;
  logic [DEPTH-1:0]    r_late;
  logic [REG_BITS-1:0] r_rd [DEPTH];
  logic [15:0]         r_stall_cnt;
  logic [15:0]         r_flush_cnt;

  logic [DEPTH-1:0]    w_v_next;
  logic [DEPTH-1:0]    w_late_next;
  logic [REG_BITS-1:0] w_rd_next [DEPTH];

  logic [FSEL_W-1:0]   w_sel_a;
  logic [FSEL_W-1:0]   w_sel_b;
  logic                w_nf_a;
  logic                w_nf_b;
  logic                w_stall;
  logic [NREGS-1:0]    w_busy;

  // Youngest-match search. Scanning from the oldest slot down to slot 0 lets
  // the last hit (lowest index) win, so a younger writer shadows older ones.
  // A hit on a late result that has not yet reached LOAD_LAT cannot be
  // forwarded and flags a stall instead.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    w_nf_a  = 1'b0;
    w_nf_b  = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (bus.id_ra_used && r_v[k] && (r_rd[k] == bus.id_ra)) begin
        w_sel_a = FSEL_W'(k + 1);
        w_nf_a  = r_late[k] && (k < LOAD_LAT);
      end
      if (bus.id_rb_used && r_v[k] && (r_rd[k] == bus.id_rb)) begin
        w_sel_b = FSEL_W'(k + 1);
        w_nf_b  = r_late[k] && (k < LOAD_LAT);
      end
    end
  end

  // A taken branch overrides any stall: the stalled consumer is squashed.
  assign w_stall = bus.id_valid & ~bus.br_taken & (w_nf_a | w_nf_b);

  always_comb begin
    w_busy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_v[k]) begin
        w_busy[r_rd[k]] = 1'b1;
      end
    end
  end

  // Next-state for each slot. Entries that sat in slots younger than the
  // branch (old slots 0..BR_STAGE-1) are squashed, and they land in new
  // slots 1..BR_STAGE; the branch itself moves on untouched.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      if (gi == 0) begin : g_head
        assign w_v_next[gi]    = bus.id_valid & bus.id_wr & ~w_stall & ~bus.br_taken;
        assign w_rd_next[gi]   = bus.id_rd;
        assign w_late_next[gi] = bus.id_late;
      end else begin : g_tail
        localparam bit SQUASH = (gi <= BR_STAGE);
        assign w_v_next[gi]    = r_v[gi-1] & ~(bus.br_taken & SQUASH);
        assign w_rd_next[gi]   = r_rd[gi-1];
        assign w_late_next[gi] = r_late[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v         <= '0;
      r_late      <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_rd[k] <= '0;
      end
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (bus.advance) begin
      r_v    <= w_v_next;
      r_late <= w_late_next;
      for (int k = 0; k < DEPTH; k++) begin
        r_rd[k] <= w_rd_next[k];
      end
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (bus.br_taken && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign bus.stall     = w_stall;
  assign bus.bubble    = w_stall;
  assign bus.flush     = bus.br_taken;
  assign bus.fwd_a     = w_nf_a ? '0 : w_sel_a;
  assign bus.fwd_b     = w_nf_b ? '0 : w_sel_b;
  assign bus.busy_regs = w_busy;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// tb_pipe_hazard_ctl
//   Directed test-plan sequences followed by random traffic. The driver keeps
//   an in-flight instruction list (youngest first) as its reference model,
//   pushes the expected response for every cycle into a queue, and a monitor
//   on the falling edge pops and compares.
module tb_pipe_hazard_ctl;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 2;
  localparam int BR_STAGE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctl_if #(.REG_BITS(3), .FSEL_W(2)) hz ();

  pipe_hazard_ctl #(
    .REG_BITS(3), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .BR_STAGE(BR_STAGE), .FSEL_W(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hz)
  );

  typedef struct packed {
    logic adv, v, wr, late, ua, ub, br;
    logic [2:0] rd, ra, rb;
  } stim_t;

  typedef struct packed {
    logic        stall, flush;
    logic [1:0]  fa, fb;
    logic [7:0]  busy;
    logic [15:0] sc, fc;
  } exp_t;

  typedef struct packed {
    logic       v;
    logic [2:0] rd;
    logic       late;
  } ent_t;

  ent_t mq[$];       // in-flight instructions, index = distance past ID
  exp_t eq[$];
  int   total = 0;
  int   bad   = 0;
  int   ms    = 0;
  int   mf    = 0;
  bit   done  = 1'b0;

  function automatic stim_t mk(input logic adv, v, wr, input logic [2:0] rd,
                               input logic late, ua, input logic [2:0] ra,
                               input logic ub, input logic [2:0] rb, input logic br);
    stim_t s;
    s.adv = adv; s.v = v; s.wr = wr; s.rd = rd; s.late = late;
    s.ua = ua; s.ra = ra; s.ub = ub; s.rb = rb; s.br = br;
    return s;
  endfunction

  function automatic int youngest(input logic used, input logic [2:0] r);
    if (!used) return -1;
    for (int k = 0; k < mq.size(); k++)
      if (mq[k].v && mq[k].rd == r) return k;
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < DEPTH; k++) mq.push_back('0);
    ms = 0;
    mf = 0;
  endtask

  task automatic step(input stim_t s, input bit rst_low);
    int   ia, ib;
    logic nfa, nfb;
    exp_t e;
    ent_t ne;
    hz.advance = s.adv;  hz.id_valid = s.v;   hz.id_wr = s.wr;
    hz.id_rd = s.rd;     hz.id_late = s.late; hz.id_ra_used = s.ua;
    hz.id_ra = s.ra;     hz.id_rb_used = s.ub; hz.id_rb = s.rb;
    hz.br_taken = s.br;
    if (rst_low) begin
      rst_n = 1'b0;
      model_reset();
    end else begin
      rst_n = 1'b1;
    end
    ia  = youngest(s.ua, s.ra);
    ib  = youngest(s.ub, s.rb);
    nfa = 1'b0;
    nfb = 1'b0;
    if (ia >= 0) nfa = mq[ia].late && (ia < LOAD_LAT);
    if (ib >= 0) nfb = mq[ib].late && (ib < LOAD_LAT);
    e       = '0;
    e.stall = s.v & ~s.br & (nfa | nfb);
    e.flush = s.br;
    e.fa    = (ia < 0 || nfa) ? 2'd0 : 2'(ia + 1);
    e.fb    = (ib < 0 || nfb) ? 2'd0 : 2'(ib + 1);
    for (int k = 0; k < mq.size(); k++)
      if (mq[k].v) e.busy[mq[k].rd] = 1'b1;
    e.sc = 16'(ms);
    e.fc = 16'(mf);
    eq.push_back(e);
    @(posedge clk);
    if (!rst_low && s.adv) begin
      if (e.stall && ms < 65535) ms++;
      if (s.br && mf < 65535) mf++;
      // Everything younger than the branch is squashed.
      if (s.br)
        for (int k = 0; k < BR_STAGE; k++) mq[k].v = 1'b0;
      ne.v    = s.v & s.wr & ~e.stall & ~s.br;
      ne.rd   = s.rd;
      ne.late = s.late;
      mq.push_front(ne);
      void'(mq.pop_back());
    end
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares once per cycle, away from the rising edge.
  initial begin : monitor
    exp_t e;
    int   n;
    n = 0;
    while (!(done && eq.size() == 0)) begin
      @(negedge clk);
      if (eq.size() > 0) begin
        e = eq.pop_front();
        chk("stall",     16'(hz.stall),     16'(e.stall));
        chk("bubble",    16'(hz.bubble),    16'(e.stall));
        chk("flush",     16'(hz.flush),     16'(e.flush));
        if (!e.flush) begin
          chk("fwd_a", 16'(hz.fwd_a), 16'(e.fa));
          chk("fwd_b", 16'(hz.fwd_b), 16'(e.fb));
        end
        chk("busy_regs", 16'(hz.busy_regs), 16'(e.busy));
        chk("stall_cnt", hz.stall_cnt,      e.sc);
        chk("flush_cnt", hz.flush_cnt,      e.fc);
        $display("txn %0d stall=%b flush=%b fa=%0d fb=%0d busy=%h sc=%0d fc=%0d",
                 n, hz.stall, hz.flush, hz.fwd_a, hz.fwd_b, hz.busy_regs,
                 hz.stall_cnt, hz.flush_cnt);
        n++;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin : driver
    stim_t idle;
    stim_t s;
    idle = mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    // Reset state, then release.
    step(idle, 1'b1);
    step(idle, 1'b1);
    step(idle, 1'b0);
    // Back-to-back ALU: ADD r1; SUB r2,r1 (rb); reader of r1 at distance 2.
    step(mk(1, 1, 1, 3'd1, 0, 0, 3'd0, 0, 3'd0, 0), 1'b0);
    step(mk(1, 1, 1, 3'd2, 0, 0, 3'd0, 1, 3'd1, 0), 1'b0);
    step(mk(1, 1, 1, 3'd0, 0, 1, 3'd1, 0, 3'd0, 0), 1'b0);
    // Load-use: LD r3; ADD r4,r3 held through two stalls, then forwarded.
    step(mk(1, 1, 1, 3'd3, 1, 0, 3'd0, 0, 3'd0, 0), 1'b0);
    repeat (3) step(mk(1, 1, 1, 3'd4, 0, 1, 3'd3, 0, 3'd0, 0), 1'b0);
    // Shadowing: LD r5; ADD r5; reader of r5.
    step(mk(1, 1, 1, 3'd5, 1, 0, 3'd0, 0, 3'd0, 0), 1'b0);
    step(mk(1, 1, 1, 3'd5, 0, 0, 3'd0, 0, 3'd0, 0), 1'b0);
    step(mk(1, 1, 0, 3'd0, 0, 1, 3'd5, 1, 3'd5, 0), 1'b0);
    // Branch flush: branch, writer r6, writer r7, then branch resolves taken.
    step(mk(1, 1, 0, 3'd0, 0, 0, 3'd0, 0, 3'd0, 0), 1'b0);
    step(mk(1, 1, 1, 3'd6, 0, 0, 3'd0, 0, 3'd0, 0), 1'b0);
    step(mk(1, 1, 1, 3'd7, 0, 0, 3'd0, 0, 3'd0, 0), 1'b0);
    step(mk(1, 1, 1, 3'd1, 0, 1, 3'd6, 0, 3'd0, 1), 1'b0);
    step(idle, 1'b0);
    // Hold: LD r4 then a consumer with advance low for five cycles.
    step(mk(1, 1, 1, 3'd4, 1, 0, 3'd0, 0, 3'd0, 0), 1'b0);
    repeat (5) step(mk(0, 1, 1, 3'd2, 0, 1, 3'd4, 0, 3'd0, 0), 1'b0);
    repeat (3) step(mk(1, 1, 1, 3'd2, 0, 1, 3'd4, 0, 3'd0, 0), 1'b0);
    // Async reset with several registers busy.
    step(mk(1, 1, 1, 3'd2, 0, 0, 3'd0, 0, 3'd0, 0), 1'b0);
    step(mk(1, 1, 1, 3'd3, 1, 0, 3'd0, 0, 3'd0, 0), 1'b0);
    step(mk(1, 1, 1, 3'd4, 0, 0, 3'd0, 0, 3'd0, 0), 1'b0);
    step(mk(1, 1, 0, 3'd0, 0, 1, 3'd3, 1, 3'd4, 0), 1'b1);
    step(mk(1, 1, 0, 3'd0, 0, 1, 3'd3, 1, 3'd4, 0), 1'b0);
    // Random traffic over a small register range to provoke hazards.
    for (int i = 0; i < 500; i++) begin
      s.adv  = ($urandom % 8) != 0;
      s.v    = ($urandom % 10) != 0;
      s.wr   = ($urandom % 4) != 0;
      s.rd   = 3'($urandom_range(0, 3));
      s.late = ($urandom % 3) == 0;
      s.ua   = ($urandom % 4) != 0;
      s.ra   = 3'($urandom_range(0, 3));
      s.ub   = ($urandom % 2) != 0;
      s.rb   = 3'($urandom_range(0, 3));
      s.br   = ($urandom % 12) == 0;
      step(s, ($urandom % 200) == 0);
    end
    done = 1'b1;
  end
endmodule
